// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first.
// One full-subtractor cell per clock feeds a registered borrow flop. A start/done
// handshake launches an operation; diff/bout hold until the next completion.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RES_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Holds the WIDTH-1 lower result bits; the MSB is joined on the final edge.
    logic [RES_W-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    logic               x_c, y_c, d_bit_c, br_nxt_c;
    logic [WIDTH-1:0]   res_full_c;

`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    // Full-subtractor cell and the result as it would look after this edge.
    always_comb begin
        x_c        = a_sr_q[0];
        y_c        = b_sr_q[0];
        d_bit_c    = x_c ^ y_c ^ br_q;
        br_nxt_c   = (~x_c & y_c) | (~x_c & br_q) | (y_c & br_q);
        res_full_c = {d_bit_c, res_q};
    end

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end

            ST_SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                br_d   = br_nxt_c;
                res_d  = res_full_c[WIDTH-1:1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    diff_d  = res_full_c;
                    bout_d  = br_nxt_c;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (res_full_c[WIDTH-1] != a_msb_q);
`endif
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers; asynchronous clear on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): scoreboard of expected results pushed
// on each accepted start and popped on each done pulse.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    int     n_checks;
    int     n_fail;
    int     cyc;
    int     last_done_cyc;
    int     ph5_dones;
    bit     ph5;
    logic [W-1:0] prev_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        exp_t e;
        r      = {1'b0, x} - {1'b0, y} - (W+1)'(c);
        e.diff = r[W-1:0];
        e.bout = r[W];
        e.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Push the expected result whenever the DUT accepts a start.
    always @(posedge clk) begin
        if (!rst && start && !busy)
            sb.push_back(model(a, b, bin));
    end

    // Pop and compare on each done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                prev_diff = e.diff;
            end
            if (ph5) begin
                ph5_dones++;
                if (last_done_cyc >= 0)
                    check("issue_interval", 32'(cyc - last_done_cyc), 32'd10);
                last_done_cyc = cyc;
            end
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tbin, input bit chk_timing);
        int  lat;
        int  bcnt;
        bit  seen;
        @(negedge clk);
        wait_idle();
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        lat   = 1;
        bcnt  = 0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            if (i == 3) check("diff_hold_mid_op", 32'(diff), 32'(prev_diff));
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        if (chk_timing) begin
            check("latency", 32'(lat), 32'd9);
            check("busy_cycles", 32'(bcnt), 32'd9);
        end
        @(negedge clk);
        check("busy_low_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        @(negedge clk);
        check("diff_hold_idle", 32'(diff), 32'(prev_diff));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        last_done_cyc = -1;
        ph5_dones     = 0;
        ph5           = 0;
        prev_diff     = '0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        // Directed cases, then a few random operands.
        run_op(8'h35, 8'h12, 1'b0, 1'b1);
        run_op(8'h00, 8'h01, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h5A, 8'h5A, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        // start held high with operands changing every cycle.
        @(negedge clk);
        wait_idle();
        ph5           = 1;
        last_done_cyc = -1;
        start         = 1'b1;
        for (int k = 0; k < 42; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 30 && (busy || sb.size() != 0); k++)
            @(negedge clk);
        check("ph5_done_count", 32'(ph5_dones), 32'd5);
        check("ph5_sb_drained", 32'(sb.size()), 32'd0);
        ph5 = 0;

        // Known nonzero result so the reset clear is visible.
        run_op(8'h00, 8'h00, 1'b1, 1'b0);

        // Reset on the 4th SHIFT cycle.
        @(negedge clk);
        a     = 8'hC3;
        b     = 8'h21;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        sb.delete();
        prev_diff = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done_sb", 32'(sb.size()), 32'd0);
        run_op(8'h35, 8'h12, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
